// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder and its word array.
// Contents:
//   WORD_W, BE_W      data word width and byte-enable width
//   mem_state_e       responder FSM state encoding
//   mem_addr_err()    flags a misaligned or out-of-range byte address
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // The word index is addr[31:2]. It is zero-extended before the compare so
  // that large addresses are caught instead of wrapping.
  function automatic logic mem_addr_err(input logic [31:0] addr,
                                        input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32-bit single-port word array.
// Writes are per byte. Reads are registered, so rdata updates on the edge
// after a read.
// Ports:
//   clk    rising-edge clock
//   en     access strobe; nothing happens while low
//   write  1 = byte-enabled write, 0 = read
//   we     per-byte write enables (used only when write=1)
//   addr   word index
//   wdata  write data
//   rdata  registered read data; holds its value between reads
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              write,
  input  logic [BE_W-1:0]   we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (write) begin
        for (int i = 0; i < BE_W; i++) begin
          if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port.
// It accepts one request at a time, waits LATENCY cycles, and performs the
// word access. It then holds the response until the requester takes it.
//
//   state | meaning
//   IDLE  | ready for a request (req_ready high)
//   WAIT  | request latched; counting down the wait states
//   RESP  | response presented; waiting for rsp_ready
//
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_write/addr/wdata/be     request fields, latched on accept
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          response fields, held stable while in RESP
//   busy                        high whenever the FSM is not in IDLE
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  mem_state_e state;
  logic [3:0] cnt;

  logic              wr_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  // load_q marks a response that carries array data. rsp_rdata is gated by
  // it, so stores, errors and reset all present zero.
  logic load_q;
  logic err_q;

  logic              accept;
  logic              acc_fire;
  logic              acc_write;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = load_q ? arr_rdata : '0;

  // With zero latency the access happens on the accept edge, so it uses the
  // live request fields. Otherwise it uses the latched copy.
  always_comb begin
    acc_fire  = 1'b0;
    acc_write = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (LATENCY == 0) begin
      acc_fire  = accept;
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_fire  = (state == WAIT) && (cnt == 4'd0);
    end
  end

  assign acc_err = mem_addr_err(acc_addr, DEPTH);

  mem_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (acc_fire && !acc_err),
    .write (acc_write),
    .we    (acc_be),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state  <= IDLE;
            load_q <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (acc_fire) begin
        load_q <= !acc_write && !acc_err;
        err_q  <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. It checks a LATENCY=2 instance with directed
// and random traffic, and a LATENCY=0 instance with back-to-back traffic.
// Expected values come from a word-array model kept in the bench.
module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LAT     = 2;
  localparam int Z_DEPTH = 16;

  logic        clk;
  logic        reset;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] z_ref   [Z_DEPTH];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  data_mem_responder #(.DEPTH(Z_DEPTH), .LATENCY(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a, input int unsigned depth);
    return (a % 4 != 0) || ((a / 4) >= depth);
  endfunction

  // One complete transaction on the LATENCY=2 instance. The response is held
  // for 'hold' cycles before it is accepted. During the hold, stray request
  // pulses are driven; they must be ignored.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er);
    int n;
    int lat;
    logic [31:0] exp_rd;
    logic        exp_er;
    exp_er = bad_addr(addr, DEPTH);
    exp_rd = 32'h0;
    if (!exp_er && !wr) exp_rd = ref_mem[addr / 4];
    rd = 32'h0;
    er = 1'b0;

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // The request has been accepted; scramble the fields so that any use of
    // the unlatched inputs shows up.
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    req_write = ~wr;

    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(LAT + 1));
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", 32'(rsp_err), 32'(exp_er));
    rd = rsp_rdata;
    er = rsp_err;

    for (int h = 0; h < hold; h++) begin
      req_valid = h[0]; req_write = 1'b1; req_addr = 32'h0; req_wdata = $urandom; req_be = 4'hF;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(exp_er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    if (wr && !exp_er) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[addr / 4][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  initial begin : main
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          n;
    int          seen;

    reset = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0; z_rsp_ready = 0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++) txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd, er);

    // Full-word store, then read it back.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    chk("t1_store_rdata", rd, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("t1_load", rd, 32'hDEADBEEF);
    chk("t1_err", 32'(er), 32'd0);

    // Single-byte store merges into the existing word.
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, rd, er);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    chk("t2_load", rd, 32'hDEADBEAA);

    // Misaligned load and out-of-range store report errors; the array is untouched.
    txn(1'b0, 32'h13, 32'h0, 4'hF, 0, rd, er);
    chk("t3_mis_err", 32'(er), 32'd1);
    chk("t3_mis_rdata", rd, 32'h0);
    txn(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, rd, er);
    chk("t3_oor_err", 32'(er), 32'd1);
    txn(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er);
    txn(1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'hF, 0, rd, er);

    // A zero-enable store completes without error and changes nothing.
    txn(1'b1, 32'h40, 32'h5A5A5A5A, 4'h0, 0, rd, er);
    chk("be0_err", 32'(er), 32'd0);
    txn(1'b0, 32'h40, 32'h0, 4'hF, 0, rd, er);

    // Back-pressure on the response.
    txn(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er);
    txn(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er);

    // Reset during the wait of a store drops the store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_busy_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rdata", rsp_rdata, 32'd0);
    chk("t5_err", 32'(rsp_err), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("t5_no_rsp", 32'(seen), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);

    // Random traffic, including misaligned and far out-of-range addresses.
    for (int t = 0; t < 60; t++) begin
      a = 32'($urandom_range(0, DEPTH + 3)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a[31:28] = 4'($urandom_range(1, 15));
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2), rd, er);
    end

    // Zero-latency instance with back-to-back traffic: stores to words 1..4,
    // then loads of the same words. rsp_ready stays high throughout.
    begin : zero_lat
      logic        ow [8];
      logic [31:0] oa [8];
      logic [31:0] od [8];
      int          q_acc [$];
      logic [31:0] q_exp [$];
      int          idx, cyc, done_rsp, last_acc;
      bit          adv;
      for (int i = 0; i < 4; i++) begin
        ow[i] = 1'b1; oa[i] = 32'((i + 1) * 4); od[i] = $urandom;
        ow[i+4] = 1'b0; oa[i+4] = 32'((i + 1) * 4); od[i+4] = 32'h0;
      end
      idx = 0; cyc = 0; done_rsp = 0; last_acc = -1; adv = 0;
      @(negedge clk);
      z_rsp_ready = 1'b1;
      z_req_valid = 1'b1; z_req_write = ow[0]; z_req_addr = oa[0]; z_req_wdata = od[0]; z_req_be = 4'hF;
      while (done_rsp < 8 && cyc < 200) begin
        if (z_rsp_valid) begin
          if (q_acc.size() > 0) begin
            chk("t6_latency", 32'(cyc - q_acc.pop_front()), 32'd1);
            chk("t6_rdata", z_rsp_rdata, q_exp.pop_front());
            chk("t6_err", 32'(z_rsp_err), 32'd0);
          end else begin
            chk("t6_spurious_rsp", 32'(z_rsp_valid), 32'd0);
          end
          done_rsp++;
        end
        if (z_req_valid && z_req_ready) begin
          // Accept, response cycle with handshake, then the next accept in the first idle cycle.
          if (last_acc >= 0) chk("t6_spacing", 32'(cyc - last_acc), 32'd2);
          last_acc = cyc;
          q_acc.push_back(cyc);
          if (ow[idx]) begin
            z_ref[oa[idx] / 4] = od[idx];
            q_exp.push_back(32'h0);
          end else begin
            q_exp.push_back(z_ref[oa[idx] / 4]);
          end
          idx++;
          adv = 1;
        end
        @(negedge clk);
        cyc++;
        if (adv) begin
          adv = 0;
          if (idx < 8) begin
            z_req_write = ow[idx]; z_req_addr = oa[idx]; z_req_wdata = od[idx];
          end else begin
            z_req_valid = 1'b0;
          end
        end
      end
      if (done_rsp < 8) chk("t6_timeout", 32'(done_rsp), 32'd8);
      z_rsp_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
